// File: rtl/tetris_piece_sequencer_pkg.sv
// Shared piece tables, FSM state codes and draw mapping
// for the active-piece sequencer.
package tetris_piece_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_SPAWN_CHK,
    ST_ACTIVE,
    ST_ROT_CHK,
    ST_GAME_OVER
  } state_t;

  localparam logic [2:0] T_I = 3'd0;
  localparam logic [2:0] T_O = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_J = 3'd3;
  localparam logic [2:0] T_T = 3'd4;
  localparam logic [2:0] T_Z = 3'd5;

  function automatic logic [3:0] base_of(
    input logic [2:0] t
  );
    logic [3:0] b;
    b = 4'd0;
    unique case (t)
      T_I: b = 4'd0;
      T_O: b = 4'd2;
      T_S: b = 4'd3;
      T_J: b = 4'd5;
      T_T: b = 4'd9;
      T_Z: b = 4'd13;
      default: b = 4'd0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] rotcnt_of(
    input logic [2:0] t
  );
    logic [2:0] c;
    c = 3'd1;
    unique case (t)
      T_I: c = 3'd2;
      T_O: c = 3'd1;
      T_S: c = 3'd2;
      T_J: c = 3'd4;
      T_T: c = 3'd4;
      T_Z: c = 3'd2;
      default: c = 3'd1;
    endcase
    return c;
  endfunction

  // Fold the two out-of-range codes back onto I and O.
  function automatic logic [2:0] draw(
    input logic [7:0] q
  );
    logic [2:0] d;
    d = q[2:0];
    if (q[2:1] == 2'b11) d = {2'b00, q[0]};
    return d;
  endfunction

endpackage

// File: rtl/tetris_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4.
// An all-zero seed would lock up, so it is replaced by 1.
module tetris_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] q
);

  localparam logic [7:0] S0 =
    (SEED == 8'h00) ? 8'h01 : SEED;

  logic fb;

  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (!resetn) q <= S0;
    else         q <= {q[6:0], fb};
  end

endmodule

// File: rtl/tetris_piece_sequencer.sv
// Active-piece owner: spawn, rotate, propose candidates
// to the collision checker and commit on fit_ok.
module tetris_piece_sequencer
  import tetris_piece_sequencer_pkg::*;
#(
  parameter logic [7:0] SEED          = 8'hA5,
  parameter int         CHECK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spawn_req,
  input  logic       rot_req,
  input  logic       fit_valid,
  input  logic       fit_ok,
  output logic       check_req,
  output logic [3:0] cand_sel,
  output logic [3:0] cfg_sel,
  output logic       piece_valid,
  output logic [2:0] next_type,
  output logic       busy,
  output logic       game_over
);

  localparam logic [3:0] TMO_LAST =
    4'(CHECK_TIMEOUT - 1);

  state_t     state, state_d;
  logic [3:0] cand_d, cfg_d, tcnt, tcnt_d;
  logic [2:0] ptype, type_d, next_d, r1;
  logic [1:0] rot, rot_d, rot_nx;
  logic       chk_d, resp, tmo;
  logic [7:0] lfsr_q;

  tetris_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .q      (lfsr_q)
  );

  assign r1     = {1'b0, rot} + 3'd1;
  assign rot_nx = (r1 == rotcnt_of(ptype)) ?
                  2'd0 : r1[1:0];

  // The pulse cycle itself never accepts a response.
  assign resp = fit_valid && !check_req;
  assign tmo  = !check_req && !fit_valid &&
                (tcnt == TMO_LAST);

  assign busy        = (state == ST_SPAWN_CHK) ||
                       (state == ST_ROT_CHK);
  assign piece_valid = (state == ST_ACTIVE) ||
                       (state == ST_ROT_CHK);
  assign game_over   = (state == ST_GAME_OVER);

  always_comb begin
    state_d = state;
    cand_d  = cand_sel;
    cfg_d   = cfg_sel;
    rot_d   = rot;
    type_d  = ptype;
    next_d  = next_type;
    chk_d   = 1'b0;
    tcnt_d  = 4'd0;
    unique case (state)
      ST_EMPTY, ST_ACTIVE: begin
        if (spawn_req) begin
          state_d = ST_SPAWN_CHK;
          type_d  = next_type;
          rot_d   = 2'd0;
          cand_d  = base_of(next_type);
          next_d  = draw(lfsr_q);
          chk_d   = 1'b1;
        end else if (rot_req &&
                     state == ST_ACTIVE) begin
          state_d = ST_ROT_CHK;
          cand_d  = base_of(ptype) + {2'b00, rot_nx};
          chk_d   = 1'b1;
        end
      end
      ST_SPAWN_CHK: begin
        if (!check_req) tcnt_d = tcnt + 4'd1;
        if (resp && fit_ok) begin
          cfg_d   = cand_sel;
          state_d = ST_ACTIVE;
        end else if (resp || tmo) begin
          state_d = ST_GAME_OVER;
        end
      end
      ST_ROT_CHK: begin
        if (!check_req) tcnt_d = tcnt + 4'd1;
        if (resp && fit_ok) begin
          cfg_d   = cand_sel;
          rot_d   = rot_nx;
          state_d = ST_ACTIVE;
        end else if (resp || tmo) begin
          cand_d  = cfg_sel;
          state_d = ST_ACTIVE;
        end
      end
      ST_GAME_OVER: begin
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_EMPTY;
      cand_sel  <= 4'd0;
      cfg_sel   <= 4'd0;
      rot       <= 2'd0;
      ptype     <= 3'd0;
      next_type <= draw(SEED);
      check_req <= 1'b0;
      tcnt      <= 4'd0;
    end else begin
      state     <= state_d;
      cand_sel  <= cand_d;
      cfg_sel   <= cfg_d;
      rot       <= rot_d;
      ptype     <= type_d;
      next_type <= next_d;
      check_req <= chk_d;
      tcnt      <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_tetris_piece_sequencer.sv
// Randomized bench for tetris_piece_sequencer against
// a transaction-level model of piece, rotation and LFSR.
module tb_tetris_piece_sequencer;

  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       spawn_req = 1'b0;
  logic       rot_req = 1'b0;
  logic       fit_valid = 1'b0;
  logic       fit_ok = 1'b0;
  logic       check_req;
  logic [3:0] cand_sel;
  logic [3:0] cfg_sel;
  logic       piece_valid;
  logic [2:0] next_type;
  logic       busy;
  logic       game_over;

  tetris_piece_sequencer #(
    .SEED          (SEED),
    .CHECK_TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .spawn_req   (spawn_req),
    .rot_req     (rot_req),
    .fit_valid   (fit_valid),
    .fit_ok      (fit_ok),
    .check_req   (check_req),
    .cand_sel    (cand_sel),
    .cfg_sel     (cfg_sel),
    .piece_valid (piece_valid),
    .next_type   (next_type),
    .busy        (busy),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int base_t[6] = '{0, 2, 3, 5, 9, 13};
  int rc_t[6]   = '{2, 1, 2, 4, 4, 2};
  int taps[4]   = '{8, 6, 5, 4};

  bit         m_act, m_over;
  int         m_type, m_rot, m_cfg, m_next;
  logic [7:0] m_lfsr;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lstep(
    input logic [7:0] q
  );
    bit fb = 1'b0;
    foreach (taps[i]) fb ^= q[taps[i] - 1];
    return {q[6:0], fb};
  endfunction

  function automatic int drawf(input logic [7:0] q);
    int v = int'(q[2:0]);
    return v % 6;
  endfunction

  always @(posedge clk)
    m_lfsr <= resetn ? lstep(m_lfsr) : SEED;

  task automatic steady(input string tag);
    check({tag, "_cfg"}, 8'(cfg_sel), 8'(m_cfg));
    check({tag, "_pv"}, 8'(piece_valid), 8'(m_act));
    check({tag, "_go"}, 8'(game_over), 8'(m_over));
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_creq"}, 8'(check_req), 8'd0);
    check({tag, "_next"}, 8'(next_type), 8'(m_next));
    if (m_act)
      check({tag, "_cand"}, 8'(cand_sel), 8'(m_cfg));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    spawn_req = 1'b0;
    rot_req = 1'b0;
    fit_valid = 1'b0;
    fit_ok = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_act = 0;
    m_over = 0;
    m_cfg = 0;
    m_rot = 0;
    m_type = 0;
    m_next = int'(SEED[2:0]) % 6;
    steady("rst");
    check("rst_cand", 8'(cand_sel), 8'd0);
  endtask

  // d == 0 means no response: the checker times out.
  task automatic respond(input bit ok, input int d,
                         output bit acc);
    acc = 1'b0;
    if (d == 0) begin
      repeat (20) @(negedge clk);
      return;
    end
    for (int i = 1; i < d; i++) begin
      @(negedge clk);
      check("wait_busy", 8'(busy), 8'd1);
      check("wait_creq", 8'(check_req), 8'd0);
    end
    @(negedge clk);
    fit_valid = 1'b1;
    fit_ok = ok;
    @(negedge clk);
    fit_valid = 1'b0;
    fit_ok = 1'b0;
    acc = 1'b1;
  endtask

  task automatic do_spawn(input bit ok, input int d,
                          input bit with_rot);
    int nt, ty;
    bit acc;
    nt = drawf(m_lfsr);
    ty = m_next;
    spawn_req = 1'b1;
    rot_req = with_rot;
    @(negedge clk);
    spawn_req = 1'b0;
    rot_req = 1'b0;
    if (m_over) begin
      steady("sp_ign");
      return;
    end
    check("sp_creq", 8'(check_req), 8'd1);
    check("sp_cand", 8'(cand_sel), 8'(base_t[ty]));
    check("sp_pv", 8'(piece_valid), 8'd0);
    check("sp_busy", 8'(busy), 8'd1);
    check("sp_next", 8'(next_type), 8'(nt));
    m_next = nt;
    m_act = 0;
    respond(ok, d, acc);
    if (acc && ok) begin
      m_act = 1;
      m_type = ty;
      m_rot = 0;
      m_cfg = base_t[ty];
    end else begin
      m_over = 1;
    end
    steady("sp_done");
  endtask

  task automatic do_rot(input bit ok, input int d);
    int cand, nr;
    bit acc;
    rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    if (!m_act) begin
      steady("rot_ign");
      return;
    end
    nr = (m_rot + 1) % rc_t[m_type];
    cand = base_t[m_type] + nr;
    check("rot_creq", 8'(check_req), 8'd1);
    check("rot_cand", 8'(cand_sel), 8'(cand));
    check("rot_busy", 8'(busy), 8'd1);
    check("rot_pv", 8'(piece_valid), 8'd1);
    respond(ok, d, acc);
    if (acc && ok) begin
      m_rot = nr;
      m_cfg = cand;
    end
    steady("rot_done");
  endtask

  task automatic do_stray();
    fit_valid = 1'b1;
    fit_ok = 1'($urandom_range(0, 1));
    @(negedge clk);
    fit_valid = 1'b0;
    fit_ok = 1'b0;
    steady("stray");
  endtask

  function automatic int pick_delay();
    if ($urandom_range(0, 11) == 0) return 0;
    return $urandom_range(1, 14);
  endfunction

  initial begin
    int r;
    m_lfsr = SEED;
    @(negedge clk);
    do_reset();
    do_rot(1'b1, 1);
    do_spawn(1'b1, 1, 1'b0);
    for (int k = 0; k < 5; k++) do_rot(1'b1, 2);
    do_rot(1'b0, 3);
    do_rot(1'b1, 0);
    do_spawn(1'b1, 4, 1'b1);
    do_stray();
    for (int n = 0; n < 220; n++) begin
      r = $urandom_range(0, 99);
      if (m_over && $urandom_range(0, 2) == 0)
        do_reset();
      else if (r < 25)
        do_spawn($urandom_range(0, 15) != 0,
                 pick_delay(),
                 $urandom_range(0, 3) == 0);
      else if (r < 90)
        do_rot($urandom_range(0, 3) != 0,
               pick_delay());
      else
        do_stray();
    end
    do_spawn(1'b0, 2, 1'b0);
    do_spawn(1'b1, 1, 1'b0);
    do_rot(1'b1, 1);
    do_reset();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
